// File: rtl/reg_file_wb_sink.sv
// Writeback sink of the RV32I pipeline: WB data mux, 32x32 register file,
// bypassed read ports and a RAW scoreboard that stalls decode.
module reg_file_wb_sink #(
  parameter int XLEN     = 32,
  parameter int WB_DELAY = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rd_addr_d,
  input  logic            wer_d,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            wer_issue,
  output logic            stall,
  input  logic            werf_contrl,
  input  logic [1:0]      wb_contrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0]     regs_q [32];
  logic [4:0]          rd_q [WB_DELAY];
  // Only the pre-WB entries need a valid bit: the WB entry is bypassed, never a hazard.
  logic [WB_DELAY-2:0] vld_q;
  logic [4:0]          rd_wb;
  logic                wb_wr;

  assign rd_wb = rd_q[WB_DELAY-1];
  assign wb_wr = werf_contrl && (rd_wb != 5'd0);

  always_comb begin
    case (wb_contrl)
      2'b00:   wb_data = alu_result;
      2'b01:   wb_data = mem_rdata;
      2'b10:   wb_data = pc_plus4;
      default: wb_data = imm;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    for (int k = 0; k < WB_DELAY-1; k++) begin
      if (vld_q[k] && (((rs1_addr != 5'd0) && (rs1_addr == rd_q[k])) ||
                       ((rs2_addr != 5'd0) && (rs2_addr == rd_q[k]))))
        stall = 1'b1;
    end
  end

  assign wer_issue = wer_d && !stall;

  // Write-first bypass: a same-cycle WB write is visible on the read ports.
  assign rs1_data = (rs1_addr == 5'd0) ? '0 :
                    (werf_contrl && (rd_wb == rs1_addr)) ? wb_data : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 :
                    (werf_contrl && (rd_wb == rs2_addr)) ? wb_data : regs_q[rs2_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int k = 0; k < WB_DELAY; k++) rd_q[k] <= '0;
    end else begin
      vld_q[0] <= wer_issue;
      for (int k = 1; k < WB_DELAY-1; k++) vld_q[k] <= vld_q[k-1];
      rd_q[0] <= rd_addr_d;
      for (int k = 1; k < WB_DELAY; k++) rd_q[k] <= rd_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_wr) begin
      regs_q[rd_wb] <= wb_data;
    end
  end

endmodule
